// File: rtl/bank_frame_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : bank_frame_reader_if
// Purpose  : Control, bank-read and output-stream bundle of the frame reader.
// Revision : 1.0 - initial release
// ============================================================================
interface bank_frame_reader_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [8:0]            read_enable;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic [8:0]            read_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_data;
    logic                  m_last_x;
    logic                  m_last;

    modport master (
        input  start,
        output busy, done,
        output read_enable, read_addr,
        input  read_data,
        output m_valid,
        input  m_ready,
        output m_data, m_last_x, m_last
    );

    modport slave (
        output start,
        input  busy, done,
        input  read_enable, read_addr,
        output read_data,
        input  m_valid,
        output m_ready,
        input  m_data, m_last_x, m_last
    );
endinterface
`default_nettype wire

// File: rtl/bank_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : bank_frame_reader
// Purpose  : Raster-order reader of a 3x3-interleaved banked cell memory,
//            emitting one cell per beat on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module bank_frame_reader #(
    parameter int ADDR_WIDTH       = 4,
    parameter int WIDTH_BLOCKS     = 2,
    parameter int HEIGHT_BLOCKS    = 2,
    parameter int PIXELS_PER_BLOCK = 3
) (
    input  logic                clk,
    input  logic                reset,
    bank_frame_reader_if.master bus
);
    localparam int c_xb_w = (WIDTH_BLOCKS  > 1) ? $clog2(WIDTH_BLOCKS)  : 1;
    localparam int c_yb_w = (HEIGHT_BLOCKS > 1) ? $clog2(HEIGHT_BLOCKS) : 1;
    localparam logic [1:0]            c_pix_last = 2'(PIXELS_PER_BLOCK - 1);
    localparam logic [c_xb_w-1:0]     c_xb_last  = c_xb_w'(WIDTH_BLOCKS - 1);
    localparam logic [c_yb_w-1:0]     c_yb_last  = c_yb_w'(HEIGHT_BLOCKS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_w_blocks = ADDR_WIDTH'(WIDTH_BLOCKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state, w_state_next;
    logic [1:0]            r_x_pix, r_y_pix;
    logic [c_xb_w-1:0]     r_x_blk;
    logic [c_yb_w-1:0]     r_y_blk;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_inflight;
    logic [3:0]            r_bank_d;
    logic                  r_last_x_d, r_last_d;
    logic [2:0]            r_fifo [2];
    logic                  r_wr_ptr, r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_issue, w_clear, w_pop, w_push;
    logic                  w_row_end, w_frame_end;
    logic [2:0]            w_occupancy;
    logic [3:0]            w_bank;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [2:0]            w_head;

    assign w_push      = r_inflight;
    assign w_pop       = (r_count != 2'd0) & bus.m_ready;
    // Slots already promised to queued or returning cells, after this cycle's pop.
    assign w_occupancy = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_row_end   = (r_x_pix == c_pix_last) && (r_x_blk == c_xb_last);
    assign w_frame_end = w_row_end && (r_y_pix == c_pix_last) && (r_y_blk == c_yb_last);
    assign w_bank      = ({2'b0, r_y_pix} * 4'd3) + {2'b0, r_x_pix};
    assign w_addr      = (ADDR_WIDTH'(r_y_blk) * c_w_blocks) + ADDR_WIDTH'(r_x_blk);
    assign w_head      = r_fifo[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_RUN;
                    w_clear      = 1'b1;
                end
            end
            S_RUN: begin
                if (w_occupancy <= 3'd1) begin
                    w_issue = 1'b1;
                    if (w_frame_end) w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_inflight && w_pop && w_head[0]) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.read_enable = w_issue ? (9'd1 << w_bank) : 9'd0;
    assign bus.read_addr   = w_issue ? w_addr : r_addr;
    assign bus.m_valid     = (r_count != 2'd0);
    assign bus.m_data      = w_head[2];
    assign bus.m_last_x    = w_head[1];
    assign bus.m_last      = w_head[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset || w_clear) begin
            r_x_pix <= '0;
            r_x_blk <= '0;
            r_y_pix <= '0;
            r_y_blk <= '0;
        end else if (w_issue) begin
            if (r_x_pix != c_pix_last) begin
                r_x_pix <= r_x_pix + 2'd1;
            end else begin
                r_x_pix <= '0;
                if (r_x_blk != c_xb_last) begin
                    r_x_blk <= r_x_blk + 1'b1;
                end else begin
                    r_x_blk <= '0;
                    if (r_y_pix != c_pix_last) begin
                        r_y_pix <= r_y_pix + 2'd1;
                    end else begin
                        r_y_pix <= '0;
                        r_y_blk <= (r_y_blk == c_yb_last) ? '0 : r_y_blk + 1'b1;
                    end
                end
            end
        end
    end

    // Bank select and flags travel alongside the read so the return can be steered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_bank_d   <= '0;
            r_last_x_d <= 1'b0;
            r_last_d   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_addr     <= w_addr;
                r_bank_d   <= w_bank;
                r_last_x_d <= w_row_end;
                r_last_d   <= w_frame_end;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= {bus.read_data[r_bank_d], r_last_x_d, r_last_d};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bank_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_frame_reader
// Purpose  : Randomized self-checking bench for bank_frame_reader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_frame_reader;
    localparam int AW   = 4;
    localparam int WB   = 2;
    localparam int HB   = 2;
    localparam int NB   = 9 * WB * HB;
    localparam int ROWW = 3 * WB;

    logic clk = 1'b0;
    logic reset;

    bank_frame_reader_if #(.ADDR_WIDTH(AW)) bus ();

    bank_frame_reader #(
        .ADDR_WIDTH      (AW),
        .WIDTH_BLOCKS    (WB),
        .HEIGHT_BLOCKS   (HB),
        .PIXELS_PER_BLOCK(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bank contents and the raster-order expectation derived from them.
    logic          mem      [9][16];
    logic [3:0]    exp_bank [NB];
    logic [AW-1:0] exp_addr [NB];
    logic          exp_data [NB];
    logic          exp_lx   [NB];
    logic          exp_l    [NB];

    task automatic prep(input bit rnd);
        for (int b = 0; b < 9; b++)
            for (int a = 0; a < 16; a++)
                mem[b][a] = rnd ? 1'($urandom % 2) : 1'((a + b) % 2);
        for (int k = 0; k < NB; k++) begin
            int y, x;
            y = k / ROWW;
            x = k % ROWW;
            exp_bank[k] = 4'((y % 3) * 3 + (x % 3));
            exp_addr[k] = AW'((y / 3) * WB + (x / 3));
            exp_data[k] = mem[exp_bank[k]][exp_addr[k]];
            exp_lx[k]   = (x == ROWW - 1);
            exp_l[k]    = (k == NB - 1);
        end
    endtask

    // Bank model: enabled banks return their cell next cycle, others return noise.
    always @(posedge clk)
        for (int b = 0; b < 9; b++)
            bus.read_data[b] <= bus.read_enable[b] ? mem[b][bus.read_addr] : 1'($urandom % 2);

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt++;

    bit mon_en = 0, expect_done = 0, fv_seen = 0;
    int beat, reads, done_cnt, fv_cycle, first_pop, last_pop;

    always @(negedge clk) begin
        if (mon_en) begin
            check_val("done_pulse", 32'(bus.done), 32'(expect_done));
            if (bus.done) done_cnt++;
            expect_done = 0;
            if (bus.read_enable != 9'd0) begin
                if (reads < NB) begin
                    check_val("rd_en", 32'(bus.read_enable), 32'(9'd1 << exp_bank[reads]));
                    check_val("rd_addr", 32'(bus.read_addr), 32'(exp_addr[reads]));
                end else begin
                    check_val("read_count", 32'(reads + 1), 32'(NB));
                end
                reads++;
            end
            if (bus.m_valid) begin
                if (!fv_seen) begin
                    fv_seen  = 1;
                    fv_cycle = cycle_cnt;
                end
                if (beat < NB) begin
                    check_val("m_data", 32'(bus.m_data), 32'(exp_data[beat]));
                    check_val("m_last_x", 32'(bus.m_last_x), 32'(exp_lx[beat]));
                    check_val("m_last", 32'(bus.m_last), 32'(exp_l[beat]));
                end else begin
                    check_val("beat_count", 32'(beat + 1), 32'(NB));
                end
                if (bus.m_ready) begin
                    if (beat == 0) first_pop = cycle_cnt;
                    last_pop = cycle_cnt;
                    if (beat == NB - 1) expect_done = 1;
                    beat++;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, 32'(bus.busy), 0);
        check_val({tag, "_done"}, 32'(bus.done), 0);
        check_val({tag, "_rd_en"}, 32'(bus.read_enable), 0);
        check_val({tag, "_rd_addr"}, 32'(bus.read_addr), 0);
        check_val({tag, "_m_valid"}, 32'(bus.m_valid), 0);
        check_val({tag, "_m_data"}, 32'(bus.m_data), 0);
        check_val({tag, "_m_last_x"}, 32'(bus.m_last_x), 0);
        check_val({tag, "_m_last"}, 32'(bus.m_last), 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: 10-cycle stall at first beat,
    // 3: extra start at beat 10, 4: reset during a stall at beat 20.
    task automatic do_frame(input int mode, input bit rnd);
        int c0, cyc, stall;
        bit pulsed;
        @(posedge clk); #1;
        prep(rnd);
        beat = 0; reads = 0; done_cnt = 0; fv_seen = 0; expect_done = 0;
        mon_en = 1;
        c0 = cycle_cnt;
        bus.start   = 1'b1;
        bus.m_ready = (mode == 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_val("busy_after_start", 32'(bus.busy), 1);
        cyc = 0; stall = 0; pulsed = 0;
        while (!bus.done && cyc < 500) begin
            if (mode == 2 && fv_seen && cycle_cnt == fv_cycle + 9) begin
                check_val("stall_reads", 32'(reads), 2);
                check_val("stall_no_read", 32'(bus.read_enable), 0);
                check_val("stall_valid", 32'(bus.m_valid), 1);
            end
            if (mode == 4 && beat >= 20) begin
                stall++;
                if (stall == 4) begin
                    reset = 1'b1;
                    #1;
                    check_all_zero("mid_reset");
                    mon_en = 0;
                    @(posedge clk); #1;
                    reset = 1'b0;
                    bus.m_ready = 1'b1;
                    repeat (3) begin
                        @(posedge clk); #1;
                        check_val("post_reset_valid", 32'(bus.m_valid), 0);
                        check_val("post_reset_busy", 32'(bus.busy), 0);
                    end
                    return;
                end
            end
            case (mode)
                0:       bus.m_ready = 1'b1;
                2:       bus.m_ready = fv_seen && (cycle_cnt >= fv_cycle + 9);
                4:       bus.m_ready = (beat >= 20) ? 1'b0 : 1'($urandom % 2);
                default: bus.m_ready = 1'($urandom % 2);
            endcase
            if (mode == 3 && beat == 10 && !pulsed) begin
                bus.start = 1'b1;
                pulsed    = 1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check_val("frame_timeout", 32'(cyc < 500), 1);
        check_val("busy_fall", 32'(bus.busy), 0);
        check_val("beats", 32'(beat), NB);
        check_val("reads", 32'(reads), NB);
        if (mode == 0) begin
            check_val("first_valid_lat", 32'(fv_cycle - c0), 3);
            check_val("back_to_back", 32'(last_pop - first_pop), NB - 1);
        end
        if (mode == 2) check_val("release_burst", 32'(last_pop - first_pop), NB - 1);
        if (mode == 1) begin
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            check_val("start_on_done_ignored", 32'(bus.busy), 0);
        end
        repeat (4) @(posedge clk);
        #1;
        check_val("no_extra_beats", 32'(beat), NB);
        check_val("single_done", 32'(done_cnt), 1);
        mon_en = 0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check_all_zero("idle");
        do_frame(0, 1'b0);
        do_frame(1, 1'b0);
        do_frame(2, 1'b1);
        do_frame(3, 1'b1);
        do_frame(4, 1'b1);
        do_frame(1, 1'b1);
        do_frame(0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
